maoin_btn_debounce: RTL and testbench

Debounces and conditions one mechanical push-button before it reaches the single-bit edge-capturing input PIO of the maoin system. It sits directly upstream of that PIO. Its debounced level drives the PIO `in_port`, so each physical press produces exactly one rising edge and one captured interrupt. It also provides single-cycle press/release strobes and a long-press flag for local fabric logic.

---
 rtl/maoin_btn_debounce_if.sv | 31 +++
 rtl/maoin_btn_debounce.sv | 123 ++++++++++++
 tb/tb_maoin_btn_debounce.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/maoin_btn_debounce_if.sv
// maoin_btn_debounce_if
// Groups the push-button signals between the pad side and the debouncer.
//   btn_raw       : raw pad level, asynchronous, pad polarity
//   btn_level     : debounced level, 1 = pressed (feeds the PIO in_port)
//   press_pulse   : one-cycle strobe on an accepted press
//   release_pulse : one-cycle strobe on an accepted release
//   long_press    : level, set after a sustained hold, cleared on release
// Modports: slave = debouncer side, master = pad/consumer side.
interface maoin_btn_debounce_if;
    logic btn_raw;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic long_press;

    modport slave (
        input  btn_raw,
        output btn_level,
        output press_pulse,
        output release_pulse,
        output long_press
    );

    modport master (
        output btn_raw,
        input  btn_level,
        input  press_pulse,
        input  release_pulse,
        input  long_press
    );
endinterface

// File: rtl/maoin_btn_debounce.sv
// maoin_btn_debounce
// Synchronizes and debounces one mechanical push-button ahead of the maoin
// edge-capturing PIO, and produces press/release strobes plus a long-press flag.
// Ports:
//   clk   : system clock (single domain)
//   reset : synchronous, active-high reset
//   btn   : maoin_btn_debounce_if.slave (btn_raw in; btn_level, press_pulse,
//           release_pulse, long_press out, all registered)
module maoin_btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LONG_CYCLES     = 50000000,
    parameter int ACTIVE_LOW      = 1,
    parameter int CNT_W           = 20,
    parameter int LONG_W          = 26
) (
    input  logic                   clk,
    input  logic                   reset,
    maoin_btn_debounce_if.slave    btn
);

    localparam logic              IDLE_PAD = (ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0]  DB_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        RELEASED,
        CHECK_PRESS,
        PRESSED,
        CHECK_RELEASE
    } state_t;

    state_t            state;
    logic              s1;
    logic              s2;
    logic              s;
    logic [CNT_W-1:0]  cnt;
    logic [LONG_W-1:0] lcnt;
    logic              level_q;
    logic              press_q;
    logic              release_q;
    logic              long_q;

    // Normalized synchronized input: 1 = pressed regardless of pad polarity.
    assign s = IDLE_PAD ? ~s2 : s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1        <= IDLE_PAD;
            s2        <= IDLE_PAD;
            state     <= RELEASED;
            cnt       <= '0;
            lcnt      <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            s1        <= btn.btn_raw;
            s2        <= s1;
            press_q   <= 1'b0;
            release_q <= 1'b0;

            // Hold timer runs through release-side bounces. lcnt saturates at
            // LONG_CYCLES-1 and the flag sets on the following edge, so it
            // rises LONG_CYCLES edges after btn_level. An accepted release
            // below overrides this.
            if (state == PRESSED || state == CHECK_RELEASE) begin
                if (lcnt == LONG_MAX) begin
                    long_q <= 1'b1;
                end else begin
                    lcnt <= lcnt + LONG_W'(1);
                end
            end

            case (state)
                RELEASED: begin
                    if (s) begin
                        state <= CHECK_PRESS;
                        cnt   <= '0;
                    end
                end
                CHECK_PRESS: begin
                    if (!s) begin
                        state <= RELEASED;
                    end else if (cnt == DB_MAX) begin
                        state   <= PRESSED;
                        level_q <= 1'b1;
                        press_q <= 1'b1;
                        lcnt    <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (!s) begin
                        state <= CHECK_RELEASE;
                        cnt   <= '0;
                    end
                end
                CHECK_RELEASE: begin
                    if (s) begin
                        state <= PRESSED;
                    end else if (cnt == DB_MAX) begin
                        state     <= RELEASED;
                        level_q   <= 1'b0;
                        release_q <= 1'b1;
                        lcnt      <= '0;
                        long_q    <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= RELEASED;
            endcase
        end
    end

    assign btn.btn_level     = level_q;
    assign btn.press_pulse   = press_q;
    assign btn.release_pulse = release_q;
    assign btn.long_press    = long_q;

endmodule

// File: tb/tb_maoin_btn_debounce.sv
// tb_maoin_btn_debounce
// Directed bench for maoin_btn_debounce with DEBOUNCE_CYCLES=4, LONG_CYCLES=20,
// ACTIVE_LOW=1. Includes a small model of the downstream edge-capture PIO.
module tb_maoin_btn_debounce;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    maoin_btn_debounce_if bif ();

    maoin_btn_debounce #(
        .DEBOUNCE_CYCLES (4),
        .LONG_CYCLES     (20),
        .ACTIVE_LOW      (1),
        .CNT_W           (3),
        .LONG_W          (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .btn   (bif.slave)
    );

    always #5 clk = ~clk;

    // Downstream PIO: 2-flop edge detect, edge_capture, irq, clear by write to addr 3.
    logic       pio_d1;
    logic       pio_d2;
    logic       edge_capture;
    logic       irq_mask;
    logic       pio_wr;
    logic [1:0] pio_addr;
    logic       irq;
    logic       irq_prev;
    int         irq_rises = 0;

    assign irq = edge_capture & irq_mask;

    always @(posedge clk) begin
        if (reset) begin
            pio_d1       <= 1'b0;
            pio_d2       <= 1'b0;
            edge_capture <= 1'b0;
        end else begin
            pio_d1 <= bif.btn_level;
            pio_d2 <= pio_d1;
            if (pio_wr && pio_addr == 2'd3)
                edge_capture <= 1'b0;
            else if (pio_d1 && !pio_d2)
                edge_capture <= 1'b1;
        end
        irq_prev <= irq;
        if (irq && !irq_prev)
            irq_rises <= irq_rises + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string phase, input int i,
                              input logic lvl, input logic pp,
                              input logic rp, input logic lp);
        check($sformatf("%s[%0d].btn_level", phase, i), bif.btn_level, lvl);
        check($sformatf("%s[%0d].press_pulse", phase, i), bif.press_pulse, pp);
        check($sformatf("%s[%0d].release_pulse", phase, i), bif.release_pulse, rp);
        check($sformatf("%s[%0d].long_press", phase, i), bif.long_press, lp);
    endtask

    initial begin
        int base;
        logic pad [0:5];

        reset       = 1'b1;
        bif.btn_raw = 1'b1;
        irq_mask    = 1'b0;
        pio_wr      = 1'b0;
        pio_addr    = 2'd0;
        irq_prev    = 1'b0;

        // Reset values: 3 reset cycles, then 10 idle cycles.
        for (int i = 0; i < 3; i++) begin
            tick();
            check_outs("reset", i, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_outs("idle", i, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Clean press then release: accepted 6 edges after the pad change.
        bif.btn_raw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            check_outs("press", i, i >= 6, i == 6, 1'b0, 1'b0);
        end
        bif.btn_raw = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check_outs("release", i, i < 6, 1'b0, i == 6, 1'b0);
        end

        // Bounce: low 2, high 1, low 3, high 2, then settle low.
        pad[0] = 1'b0; pad[1] = 1'b0; pad[2] = 1'b1;
        pad[3] = 1'b0; pad[4] = 1'b0; pad[5] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bif.btn_raw = pad[i];
            tick();
            check_outs("bounce", i, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 2; i++) begin
            bif.btn_raw = 1'b1;
            tick();
            check_outs("bounce_hi", i, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        bif.btn_raw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            check_outs("settle", i, i >= 6, i == 6, 1'b0, 1'b0);
        end
        bif.btn_raw = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check_outs("settle_rel", i, i < 6, 1'b0, i == 6, 1'b0);
        end

        // Long press with a 2-cycle release glitch at cycle 10.
        for (int i = 0; i < 30; i++) begin
            bif.btn_raw = (i == 10 || i == 11);
            tick();
            check_outs("long", i, i >= 6, i == 6, 1'b0, i >= 26);
        end
        bif.btn_raw = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check_outs("long_rel", i, i < 6, 1'b0, i == 6, i < 6);
        end

        // Reset mid-press: outputs drop silently, press re-detected afterwards.
        bif.btn_raw = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            check_outs("pre_rst", i, i >= 6, i == 6, 1'b0, 1'b0);
        end
        reset = 1'b1;
        tick();
        check_outs("mid_rst", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            check_outs("post_rst", i, i >= 6, i == 6, 1'b0, 1'b0);
        end
        bif.btn_raw = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check_outs("post_rst_rel", i, i < 6, 1'b0, i == 6, 1'b0);
        end

        // Downstream PIO: clear any stale capture, then enable the mask.
        pio_wr   = 1'b1;
        pio_addr = 2'd3;
        tick();
        pio_wr   = 1'b0;
        irq_mask = 1'b1;
        tick();
        check("pio_idle.irq", irq, 1'b0);
        base = irq_rises;

        pad[0] = 1'b0; pad[1] = 1'b1; pad[2] = 1'b0;
        pad[3] = 1'b0; pad[4] = 1'b1; pad[5] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bif.btn_raw = pad[i];
            tick();
        end
        bif.btn_raw = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        check("pio_press.edge_capture", edge_capture, 1'b1);
        check("pio_press.irq", irq, 1'b1);
        check_int("pio_press.irq_rises", irq_rises - base, 1);

        pio_wr   = 1'b1;
        pio_addr = 2'd3;
        tick();
        pio_wr   = 1'b0;
        check("pio_clear.irq", irq, 1'b0);

        bif.btn_raw = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check($sformatf("pio_rel[%0d].irq", i), irq, 1'b0);
        end
        check("pio_rel.edge_capture", edge_capture, 1'b0);
        check_int("pio_rel.irq_rises", irq_rises - base, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
